// File: rtl/direction_encoder.sv
// Debounced four-button direction encoder: turns raw push-buttons into single-cycle
// one-hot move commands with a first-press pulse followed by typematic auto-repeat.
module direction_encoder #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd12500000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] dir_code,
    output logic [3:0] held
);

    localparam int DW   = $clog2(int'(DEBOUNCE_CYCLES) + 1);
    localparam int TW_D = $clog2(int'(REPEAT_DELAY));
    localparam int TW_P = $clog2(int'(REPEAT_PERIOD));
    localparam int TW   = (TW_D > TW_P) ? TW_D : TW_P;

    localparam logic [DW-1:0] DEB_LIMIT   = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 24'd1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 24'd1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    logic [3:0] raw;
    logic [3:0] stable;
    logic [3:0] sel;

    state_t        state_reg;
    logic [3:0]    cur_reg;
    logic [TW-1:0] timer_reg;

    assign raw  = {btn_up, btn_down, btn_left, btn_right};
    assign held = stable;

    // Per-button 2-flop synchronizer followed by a persistence-count debouncer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic          meta_reg;
            logic          sync_reg;
            logic          stable_reg;
            logic [DW-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg   <= 1'b0;
                    sync_reg   <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    meta_reg <= raw[gi];
                    sync_reg <= meta_reg;
                    if (sync_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LIMIT) begin
                        stable_reg <= sync_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DW'(1);
                    end
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    always_comb begin
        sel = 4'b0000;
        if (stable[3])      sel = 4'b1000;
        else if (stable[2]) sel = 4'b0100;
        else if (stable[1]) sel = 4'b0010;
        else if (stable[0]) sel = 4'b0001;
    end

    // A direction change arriving right after a pulse waits one cycle so pulses never abut;
    // every reload is at least 1, so the timer cannot underflow during that wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cur_reg   <= 4'b0000;
            timer_reg <= '0;
            dir_code  <= 4'b0000;
        end else begin
            dir_code <= 4'b0000;
            if (!en) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (sel != 4'b0000) begin
                            dir_code  <= sel;
                            cur_reg   <= sel;
                            timer_reg <= DELAY_LOAD;
                            state_reg <= DELAY;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (sel == 4'b0000) begin
                            state_reg <= IDLE;
                        end else if (sel != cur_reg && dir_code == 4'b0000) begin
                            dir_code  <= sel;
                            cur_reg   <= sel;
                            timer_reg <= DELAY_LOAD;
                            state_reg <= DELAY;
                        end else if (timer_reg == '0) begin
                            dir_code  <= cur_reg;
                            timer_reg <= PERIOD_LOAD;
                            state_reg <= REPEAT;
                        end else begin
                            timer_reg <= timer_reg - TW'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_direction_encoder.sv
// Directed bench for direction_encoder with small debounce/repeat constants.
module tb_direction_encoder;

    localparam logic [15:0] DEB = 16'd4;
    localparam logic [23:0] RD  = 24'd10;
    localparam logic [23:0] RP  = 24'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [3:0] dir_code;
    logic [3:0] held;

    always #5 clk = ~clk;

    direction_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .dir_code (dir_code),
        .held     (held)
    );

    typedef struct {
        logic [3:0] btns;
        logic [3:0] exp_code;
    } vec_t;

    vec_t       vecs [8];
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    int         pcyc [$];
    logic [3:0] pcode[$];
    int         ecyc [$];
    logic [3:0] ecode[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_btns(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    // One clock edge; outputs are sampled 1ns after it and pulses are logged by edge index.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!$onehot0(dir_code)) check("onehot", 32'(dir_code), 32'(0));
        if (dir_code != 4'b0000) begin
            pcyc.push_back(cyc);
            pcode.push_back(dir_code);
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic clear_log();
        pcyc.delete();
        pcode.delete();
        ecyc.delete();
        ecode.delete();
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] code);
        ecyc.push_back(c);
        ecode.push_back(code);
    endtask

    task automatic compare_pulses(input string name);
        int n;
        check($sformatf("%s_count", name), 32'(pcyc.size()), 32'(ecyc.size()));
        n = (pcyc.size() < ecyc.size()) ? pcyc.size() : ecyc.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_edge%0d", name, i), 32'(pcyc[i]), 32'(ecyc[i]));
            check($sformatf("%s_code%0d", name, i), 32'(pcode[i]), 32'(ecode[i]));
        end
    endtask

    initial begin
        int         base;
        logic [3:0] held_or;

        vecs[0] = '{4'b1000, 4'b1000};
        vecs[1] = '{4'b0100, 4'b0100};
        vecs[2] = '{4'b0010, 4'b0010};
        vecs[3] = '{4'b0001, 4'b0001};
        vecs[4] = '{4'b1111, 4'b1000};
        vecs[5] = '{4'b0110, 4'b0100};
        vecs[6] = '{4'b0011, 4'b0010};
        vecs[7] = '{4'b1001, 4'b1000};

        rst = 1'b1;
        en  = 1'b1;
        set_btns(4'b1111);
        repeat (4) tick();
        check("reset_dir", 32'(dir_code), 32'(0));
        check("reset_held", 32'(held), 32'(0));
        set_btns(4'b0000);
        rst = 1'b0;
        repeat (10) tick();
        check("post_reset_held", 32'(held), 32'(0));

        // Single taps: press at edge 0 for 8 cycles, one pulse at edge 7, held 6..13.
        for (int i = 0; i < 8; i++) begin
            clear_log();
            base = cyc + 1;
            set_btns(vecs[i].btns);
            run_to(base + 5);
            check($sformatf("vec%0d_held_pre", i), 32'(held), 32'(0));
            run_to(base + 6);
            check($sformatf("vec%0d_held_on", i), 32'(held), 32'(vecs[i].btns));
            run_to(base + 7);
            set_btns(4'b0000);
            run_to(base + 14);
            check($sformatf("vec%0d_held_off", i), 32'(held), 32'(0));
            run_to(base + 25);
            expect_pulse(base + 7, vecs[i].exp_code);
            compare_pulses($sformatf("vec%0d", i));
        end

        // Auto-repeat: released so that held drops right after the edge-37 repeat.
        clear_log();
        base = cyc + 1;
        set_btns(4'b0001);
        run_to(base + 34);
        set_btns(4'b0000);
        run_to(base + 40);
        check("hold_held_on", 32'(held), 32'(4'b0001));
        run_to(base + 41);
        check("hold_held_off", 32'(held), 32'(0));
        run_to(base + 60);
        expect_pulse(base + 7, 4'b0001);
        expect_pulse(base + 17, 4'b0001);
        expect_pulse(base + 22, 4'b0001);
        expect_pulse(base + 27, 4'b0001);
        expect_pulse(base + 32, 4'b0001);
        expect_pulse(base + 37, 4'b0001);
        compare_pulses("hold");

        clear_log();
        held_or = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            set_btns((k % 2 == 0) ? 4'b0010 : 4'b0000);
            tick();
            held_or |= held;
            tick();
            held_or |= held;
        end
        set_btns(4'b0000);
        repeat (20) begin
            tick();
            held_or |= held;
        end
        check("bounce_held", 32'(held_or), 32'(0));
        compare_pulses("bounce");

        // Up pressed during left's DELAY preempts it and restarts the delay.
        clear_log();
        base = cyc + 1;
        set_btns(4'b0010);
        run_to(base + 8);
        set_btns(4'b1010);
        run_to(base + 14);
        check("prio_held_left", 32'(held), 32'(4'b0010));
        run_to(base + 15);
        check("prio_held_both", 32'(held), 32'(4'b1010));
        run_to(base + 21);
        set_btns(4'b0000);
        run_to(base + 40);
        expect_pulse(base + 7, 4'b0010);
        expect_pulse(base + 16, 4'b1000);
        expect_pulse(base + 26, 4'b1000);
        compare_pulses("prio");

        clear_log();
        en   = 1'b0;
        base = cyc + 1;
        set_btns(4'b0100);
        run_to(base + 11);
        check("en_held", 32'(held), 32'(4'b0100));
        check("en_off_pulses", 32'(pcyc.size()), 32'(0));
        en = 1'b1;
        run_to(base + 17);
        set_btns(4'b0000);
        run_to(base + 40);
        expect_pulse(base + 12, 4'b0100);
        expect_pulse(base + 22, 4'b0100);
        compare_pulses("enable");

        // Asynchronous reset landing on a repeat pulse, button kept pressed throughout.
        clear_log();
        base = cyc + 1;
        set_btns(4'b1000);
        run_to(base + 22);
        check("rst_pre_pulse", 32'(dir_code), 32'(4'b1000));
        expect_pulse(base + 7, 4'b1000);
        expect_pulse(base + 17, 4'b1000);
        expect_pulse(base + 22, 4'b1000);
        compare_pulses("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_dir", 32'(dir_code), 32'(0));
        check("rst_async_held", 32'(held), 32'(0));
        tick();
        tick();
        check("rst_hold_held", 32'(held), 32'(0));
        rst = 1'b0;
        clear_log();
        base = cyc + 1;
        run_to(base + 5);
        check("rst_resume_held_pre", 32'(held), 32'(0));
        run_to(base + 6);
        check("rst_resume_held", 32'(held), 32'(4'b1000));
        run_to(base + 7);
        set_btns(4'b0000);
        run_to(base + 30);
        expect_pulse(base + 7, 4'b1000);
        compare_pulses("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
